// File: rtl/sad_min_tracker.sv
// sad_min_tracker: accumulates row SADs into block SADs, one block per
// candidate motion vector, and tracks the lowest block SAD and its index
// across a search of CAND_NUM candidates.
module sad_min_tracker #(
  parameter int ELEMENT_BIT_DEPTH = 14,
  parameter int ROWS              = 8,
  parameter int SAD_BIT_DEPTH     = 17,
  parameter int CAND_NUM          = 64,
  parameter int CAND_BITS         = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         row_valid,
  input  logic [ELEMENT_BIT_DEPTH-1:0] row_sum,
  output logic                         row_ready,
  output logic                         busy,
  output logic                         done,
  output logic [SAD_BIT_DEPTH-1:0]     best_sad,
  output logic [CAND_BITS-1:0]         best_idx
);

  localparam int ROW_BITS = (ROWS > 1) ? $clog2(ROWS) : 1;
  // One bit wider than either operand so the add can never overflow
  // before the saturation test.
  localparam int SUM_W    = ((SAD_BIT_DEPTH > ELEMENT_BIT_DEPTH) ?
                             SAD_BIT_DEPTH : ELEMENT_BIT_DEPTH) + 1;
  localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-SAD_BIT_DEPTH){1'b0}},
                                          {SAD_BIT_DEPTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_CMP   = 2'd2
  } state_t;

  state_t                     r_state;
  logic [SAD_BIT_DEPTH-1:0]   r_acc;
  logic [ROW_BITS-1:0]        r_row_cnt;
  logic [CAND_BITS-1:0]       r_cand_cnt;
  logic [SAD_BIT_DEPTH-1:0]   r_best_sad;
  logic [CAND_BITS-1:0]       r_best_idx;
  logic                       r_row_ready;
  logic                       r_busy;
  logic                       r_done;

  logic [SUM_W-1:0]           w_sum;
  logic [SAD_BIT_DEPTH-1:0]   w_acc_next;
  logic                       w_xfer;
  logic                       w_last_row;
  logic                       w_last_cand;
  logic                       w_better;

  // Saturating accumulate: clamp to all-ones instead of wrapping, so a
  // narrow accumulator still orders oversized blocks as "worst".
  assign w_sum       = SUM_W'(r_acc) + SUM_W'(row_sum);
  assign w_acc_next  = (w_sum > SAT_MAX) ? SAT_MAX[SAD_BIT_DEPTH-1:0]
                                         : w_sum[SAD_BIT_DEPTH-1:0];
  assign w_xfer      = row_valid && r_row_ready;
  assign w_last_row  = (r_row_cnt == ROW_BITS'(ROWS - 1));
  assign w_last_cand = (r_cand_cnt == CAND_BITS'(CAND_NUM - 1));
  // Strict compare: on a tie the earlier candidate keeps the slot.
  assign w_better    = (r_acc < r_best_sad);

  assign row_ready = r_row_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign best_sad  = r_best_sad;
  assign best_idx  = r_best_idx;

  // Search FSM with registered handshake/status outputs; start has
  // priority over everything, including a coincident row or done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_row_cnt   <= '0;
      r_cand_cnt  <= '0;
      r_best_sad  <= '1;
      r_best_idx  <= '0;
      r_row_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_state     <= S_ACCUM;
        r_acc       <= '0;
        r_row_cnt   <= '0;
        r_cand_cnt  <= '0;
        r_best_sad  <= '1;
        r_best_idx  <= '0;
        r_row_ready <= 1'b1;
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_row_ready <= 1'b0;
            r_busy      <= 1'b0;
          end
          S_ACCUM: begin
            if (w_xfer) begin
              r_acc <= w_acc_next;
              if (w_last_row) begin
                r_row_cnt   <= '0;
                r_state     <= S_CMP;
                r_row_ready <= 1'b0;
              end else begin
                r_row_cnt <= r_row_cnt + ROW_BITS'(1);
              end
            end
          end
          S_CMP: begin
            if (w_better) begin
              r_best_sad <= r_acc;
              r_best_idx <= r_cand_cnt;
            end
            r_acc     <= '0;
            r_row_cnt <= '0;
            if (w_last_cand) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_row_ready <= 1'b0;
            end else begin
              r_cand_cnt  <= r_cand_cnt + CAND_BITS'(1);
              r_state     <= S_ACCUM;
              r_row_ready <= 1'b1;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_row_ready <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker: two instances (17-bit and 14-bit
// accumulators, 4 candidates each) share the row bus; each has its own
// start and its own done monitor.
module tb_sad_min_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        row_valid = 1'b0;
  logic [13:0] row_sum = '0;

  logic        rdy_a, busy_a, done_a;
  logic [16:0] sad_a;
  logic [5:0]  idx_a;
  logic        rdy_b, busy_b, done_b;
  logic [13:0] sad_b;
  logic [5:0]  idx_b;

  sad_min_tracker #(.ELEMENT_BIT_DEPTH(14), .ROWS(8), .SAD_BIT_DEPTH(17),
                    .CAND_NUM(4), .CAND_BITS(6)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .row_valid(row_valid),
    .row_sum(row_sum), .row_ready(rdy_a), .busy(busy_a), .done(done_a),
    .best_sad(sad_a), .best_idx(idx_a));

  sad_min_tracker #(.ELEMENT_BIT_DEPTH(14), .ROWS(8), .SAD_BIT_DEPTH(14),
                    .CAND_NUM(4), .CAND_BITS(6)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .row_valid(row_valid),
    .row_sum(row_sum), .row_ready(rdy_b), .busy(busy_b), .done(done_b),
    .best_sad(sad_b), .best_idx(idx_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sad;
    int idx;
    int lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   sel = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int cur_sad();
    return sel ? int'(sad_b) : int'(sad_a);
  endfunction

  function automatic int cur_idx();
    return sel ? int'(idx_b) : int'(idx_a);
  endfunction

  // Done monitor: samples just after each rising edge, tracks start time
  // and ready-low cycles, pops and checks one expectation per done pulse.
  task automatic mon(input bit b);
    int   t0 = 0;
    int   low = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (b ? start_b : start_a) begin
        t0  = cyc;
        low = 0;
      end
      if ((b ? busy_b : busy_a) && !(b ? rdy_b : rdy_a)) low++;
      if (b ? done_b : done_a) begin
        if ((b ? qb.size() : qa.size()) == 0) begin
          chk($sformatf("unexpected_done_%0d", b), 1, 0);
        end else begin
          e = b ? qb.pop_front() : qa.pop_front();
          chk($sformatf("final_sad_%0d", b),
              b ? int'(sad_b) : int'(sad_a), e.sad);
          chk($sformatf("final_idx_%0d", b),
              b ? int'(idx_b) : int'(idx_a), e.idx);
          chk($sformatf("busy_at_done_%0d", b),
              int'(b ? busy_b : busy_a), 0);
          chk($sformatf("ready_low_cycles_%0d", b), low, 4);
          if (e.lat > 0) chk($sformatf("done_latency_%0d", b), cyc - t0, e.lat);
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after transfer.
  task automatic send_row(input int v, input int gap);
    int t;
    row_valid = 1'b0;
    repeat (gap) @(negedge clk);
    row_valid = 1'b1;
    row_sum   = 14'(v);
    t = 0;
    while (!(sel ? rdy_b : rdy_a) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("row_ready_timeout", 0, 1);
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_search(input bit b, input bit do_start, input bit gaps,
                            input bit abort_last, input int v[4],
                            input int es[4], input int ei[4], input int lat);
    exp_t e;
    sel = b;
    if (!abort_last) begin
      e.sad = es[3];
      e.idx = ei[3];
      e.lat = lat;
      if (b) qb.push_back(e); else qa.push_back(e);
    end
    if (do_start) pulse_start(b);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++)
        send_row(v[c], (gaps && r != 0) ? int'($urandom_range(0, 2)) : 0);
      if (abort_last && c == 3) begin
        pulse_start(b);
      end else if (!gaps) begin
        @(negedge clk);
        chk($sformatf("best_sad_cand%0d", c), cur_sad(), es[c]);
        chk($sformatf("best_idx_cand%0d", c), cur_idx(), ei[c]);
      end
    end
  endtask

  task automatic stimulus();
    // Reset asserted between edges must act at once.
    #2 rst = 1'b1;
    #1;
    chk("rst_best_sad_a", int'(sad_a), 'h1FFFF);
    chk("rst_best_sad_b", int'(sad_b), 'h3FFF);
    chk("rst_best_idx_a", int'(idx_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_ready_a", int'(rdy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ready_a", int'(rdy_a), 0);
    chk("idle_busy_a", int'(busy_a), 0);

    // Basic search, continuous valid, tie on candidate 2.
    run_search(0, 1, 0, 0, '{100, 50, 50, 10}, '{800, 400, 400, 80},
               '{0, 1, 1, 3}, 36);
    repeat (3) @(negedge clk);
    chk("stable_sad_after_done", int'(sad_a), 80);
    chk("stable_idx_after_done", int'(idx_a), 3);

    // Saturation on the 14-bit instance.
    run_search(1, 1, 0, 0, '{16383, 16383, 16383, 16383},
               '{16383, 16383, 16383, 16383}, '{0, 0, 0, 0}, 36);
    repeat (3) @(negedge clk);

    // Gaps plus rows offered during the compare cycle.
    run_search(0, 1, 1, 0, '{100, 50, 50, 10}, '{800, 400, 400, 80},
               '{0, 1, 1, 3}, 0);
    repeat (3) @(negedge clk);

    // Abort inside candidate 2 with a row offered on the restart edge.
    sel = 1'b0;
    pulse_start(0);
    for (int r = 0; r < 8; r++) send_row(100, 0);
    for (int r = 0; r < 8; r++) send_row(50, 0);
    for (int r = 0; r < 3; r++) send_row(50, 0);
    row_valid = 1'b1;
    row_sum   = 14'd999;
    start_a   = 1'b1;
    @(negedge clk);
    start_a   = 1'b0;
    row_valid = 1'b0;
    run_search(0, 0, 0, 0, '{20, 20, 20, 20}, '{160, 160, 160, 160},
               '{0, 0, 0, 0}, 36);
    repeat (3) @(negedge clk);

    // Start on the edge where done would pulse: done suppressed.
    run_search(0, 1, 0, 1, '{100, 50, 50, 10}, '{800, 400, 400, 80},
               '{0, 1, 1, 3}, 0);
    run_search(0, 0, 0, 0, '{20, 20, 20, 20}, '{160, 160, 160, 160},
               '{0, 0, 0, 0}, 36);
    repeat (3) @(negedge clk);

    // Async reset in the middle of candidate 1.
    pulse_start(0);
    for (int r = 0; r < 8; r++) send_row(100, 0);
    for (int r = 0; r < 3; r++) send_row(50, 0);
    chk("pre_rst_best_sad", int'(sad_a), 800);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_best_sad", int'(sad_a), 'h1FFFF);
    chk("mid_rst_best_idx", int'(idx_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_ready", int'(rdy_a), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", int'(rdy_a), 0);
    run_search(0, 1, 0, 0, '{100, 50, 50, 10}, '{800, 400, 400, 80},
               '{0, 1, 1, 3}, 36);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    fork
      mon(1'b0);
      mon(1'b1);
      stimulus();
      begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
      end
    join_any
    disable fork;
    chk("pending_expect_a", qa.size(), 0);
    chk("pending_expect_b", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_min_tracker.md
# sad_min_tracker

Downstream consumer of the 8-input row adder tree in the motion-estimation datapath. Accumulates successive row sums into a block SAD for each candidate motion vector, compares each completed block SAD against the running minimum, and reports the lowest SAD and its candidate index once all candidates of a search have been processed. One bubble cycle per candidate for the compare step; no other stalls are self-imposed.

## Interface

**Parameters**
- `ELEMENT_BIT_DEPTH`, default 14: width of one incoming row sum; matches the adder tree output width.
- `ROWS`, default 8: row sums per candidate block.
- `SAD_BIT_DEPTH`, default 17: accumulator and `best_sad` width.
- `CAND_NUM`, default 64: candidates per search.
- `CAND_BITS`, default 6: width of candidate index; must satisfy 2^CAND_BITS ≥ CAND_NUM.

**Ports**
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins a new search.
- `row_valid` input 1: `row_sum` is valid this cycle.
- `row_sum` input ELEMENT_BIT_DEPTH: one row's sum of absolute differences, unsigned.
- `row_ready` output 1: block accepts a row this cycle; a transfer occurs when `row_valid && row_ready`.
- `busy` output 1: search in progress.
- `done` output 1: one-cycle pulse when the search completes.
- `best_sad` output SAD_BIT_DEPTH: minimum block SAD found so far, unsigned.
- `best_idx` output CAND_BITS: candidate index of `best_sad`.

## Operation

**FSM states:** IDLE, ACCUM, CMP.
- **IDLE:** `row_ready`=0, `busy`=0. `start` → clear accumulator, row counter and candidate counter; set `best_sad` to all-ones and `best_idx`=0; go to ACCUM.
- **ACCUM:** `row_ready`=1, `busy`=1.
  - Each transfer adds the zero-extended `row_sum` into the accumulator and increments the row counter.
  - The transfer that is the ROWS-th row moves to CMP.
  - Idle cycles (`row_valid`=0) change nothing.
- **CMP:** `row_ready`=0, `busy`=1.
  - If accumulator < `best_sad` (strict), load `best_sad` = accumulator and `best_idx` = candidate counter. On a tie, the earlier candidate wins.
  - Clear accumulator and row counter.
  - If candidate counter = CAND_NUM-1: pulse `done`, go to IDLE.
  - Otherwise: increment the candidate counter and return to ACCUM.

**Arithmetic:** the accumulator saturates at 2^SAD_BIT_DEPTH-1 and never wraps. This applies to parameter overrides where SAD_BIT_DEPTH < ELEMENT_BIT_DEPTH+log2(ROWS).

**Boundary conditions:**
- `start` in ACCUM or CMP aborts the current search and restarts exactly as from IDLE. Results of the aborted search are discarded and `done` is not pulsed.
- `start` coinciding with a row transfer: the restart wins and the row is dropped.
- `start` in the same cycle `done` would pulse: `done` is suppressed and the new search begins.
- `row_valid` while `row_ready`=0: ignored; the source must hold the row.
- `best_sad`/`best_idx` remain stable after `done` until the next `start` or `rst`.

## Timing

**Reset values** (on `rst` assertion, asynchronously, in any state):
- FSM → IDLE
- `row_ready`=0, `busy`=0, `done`=0
- `best_sad`=all-ones, `best_idx`=0
- accumulator and counters = 0

**Cycle behaviour:**
- `start` sampled at edge E0: `busy` and `row_ready` high from E0 onward.
- The final row of a candidate transferred at edge E: CMP during the cycle after E. `best_sad`/`best_idx` update at E+1; `row_ready` returns high after E+1.
- Last candidate: `done` high for exactly the cycle after E+1, coincident with `busy` low and valid final outputs.
- Minimum search duration with `row_valid` held high: CAND_NUM×(ROWS+1) cycles from `start` to `done`.

## Test plan

- **Reset:** assert `rst` mid-cycle with no clock edge → outputs immediately at reset values (`best_sad`=0x1FFFF, `busy`=0); `row_ready` stays 0 without `start`.
- **Basic search** (CAND_NUM=4, continuous valid): rows of 100, 50, 50, 10 per candidate → intermediate `best_sad` 800/idx0 then 400/idx1. Tie with candidate 2 keeps idx1. Final `best_sad`=80, `best_idx`=3, `done` 36 cycles after `start`.
- **Backpressure and gaps:** same stimulus with random `row_valid` gaps and rows offered during CMP → identical final result; no row lost or double-counted; `row_ready` low exactly one cycle per candidate.
- **Saturation** (SAD_BIT_DEPTH=14): eight rows of 16383 on every candidate → `best_sad`=16383, `best_idx`=0.
- **Abort and restart:** `start` during candidate 2 of a search, then a full search of constant 20-per-row rows → no `done` for the aborted search; final `best_sad`=160, `best_idx`=0.
- **Async reset mid-search:** `rst` during candidate 1 → immediate reset values; the next `start` runs a clean search.
